// File: rtl/wb_regfile.sv
// wb_regfile: MEM/WB writeback commit into the 32x32 MIPS register file.
// It selects the writeback value and commits it to the register file.
// It serves two combinational ID-stage read ports and counts retired writes.
// Optional build macro WB_REGFILE_BYPASS_EN adds a same-cycle write-to-read
// bypass on both read ports. When the macro is undefined, a read returns the
// stored value and a new write is visible from the next cycle.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite,
    input  logic            MemtoReg,
    input  logic [DW-1:0]   ReadData,
    input  logic [DW-1:0]   ALURes,
    input  logic [4:0]      dst,
    input  logic [4:0]      rs,
    input  logic [4:0]      rt,
    output logic [DW-1:0]   rsData,
    output logic [DW-1:0]   rtData,
    output logic [DW-1:0]   WBData,
    output logic            WBValid,
    output logic [CNTW-1:0] WrCount
);

    // Entry 0 exists but is never written. Reads of index 0 are masked to zero.
    logic [DW-1:0] regs [NREG];

    // Writeback value select and commit qualifier; $zero is never a target.
    assign WBData  = MemtoReg ? ReadData : ALURes;
    assign WBValid = RegWrite && (dst != 5'd0);

    // Register file commit. Reset clears every entry and drops any in-flight write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the array is cleared explicitly so reads never see X after reset;
            // this keeps it out of plain RAM inference, which is fine at 32 entries.
            for (int i = 0; i < NREG; i++) begin
                // NOTE: non-blocking assignments for all clocked state, so every
                // reader sees the pre-edge value regardless of block ordering.
                regs[i] <= '0;
            end
        end else if (WBValid) begin
            regs[dst] <= WBData;
        end
    end

    // Retired-write counter. It wraps modulo 2^CNTW and does not saturate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            WrCount <= '0;
        end else if (WBValid) begin
            WrCount <= WrCount + 1'b1;
        end
    end

    // Read port A: $zero masking, then the optional same-cycle bypass.
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        rsData = '0;
        if (rs != 5'd0) begin
            rsData = regs[rs];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (WBValid && (rs == dst)) begin
            rsData = WBData;
        end
`endif
    end

    // Read port B: same rules as port A, bypassed independently.
    always_comb begin
        rtData = '0;
        if (rt != 5'd0) begin
            rtData = regs[rt];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (WBValid && (rt == dst)) begin
            rtData = WBData;
        end
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: checks wb_regfile against an array model of the architectural
// register file, using directed steps followed by a randomized stretch.
// WrCount is built narrow (CNTW=4) so the wrap is reachable quickly.
// The expected read results follow WB_REGFILE_BYPASS_EN in the same way as the DUT build.
module tb_wb_regfile;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            RegWrite;
    logic            MemtoReg;
    logic [31:0]     ReadData;
    logic [31:0]     ALURes;
    logic [4:0]      dst;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [31:0]     rsData;
    logic [31:0]     rtData;
    logic [31:0]     WBData;
    logic            WBValid;
    logic [CNTW-1:0] WrCount;

    wb_regfile #(.NREG(32), .DW(32), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ReadData(ReadData), .ALURes(ALURes), .dst(dst), .rs(rs), .rt(rt),
        .rsData(rsData), .rtData(rtData), .WBData(WBData), .WBValid(WBValid),
        .WrCount(WrCount)
    );

    always #5 clk = ~clk;

    // Reference state: architectural registers and the number of committed writes.
    logic [31:0] model [32];
    int unsigned modelCount;
    int nChecks = 0;
    int nFails  = 0;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural read: $zero reads 0. A register being written this cycle
    // shows its new value only in the bypass build.
    function automatic logic [31:0] expRead(input logic [4:0] idx, input bit wbv,
                                            input logic [4:0] d, input logic [31:0] wbd);
        if (idx == 5'd0) return 32'd0;
        if (BYPASS && wbv && (idx == d)) return wbd;
        return model[idx];
    endfunction

    // One clock cycle. Drive the bundle, check the combinational outputs
    // mid-cycle, then let the edge commit and advance the model.
    task automatic step(input logic rw, input logic mtr, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b, input logic rstn, input bit chkRead);
        bit          wbv;
        logic [31:0] wbd;
        RegWrite = rw;  MemtoReg = mtr; ReadData = rd; ALURes = alu;
        dst = d; rs = a; rt = b; reset = rstn;
        wbv = rw && (d != 5'd0);
        wbd = mtr ? rd : alu;
        #2;
        check("WBData", WBData, wbd);
        check("WBValid", {31'd0, WBValid}, {31'd0, wbv});
        if (chkRead) begin
            check("rsData", rsData, expRead(a, wbv, d, wbd));
            check("rtData", rtData, expRead(b, wbv, d, wbd));
            check("WrCount", {{(32-CNTW){1'b0}}, WrCount}, modelCount);
        end
        @(posedge clk);
        if (!rstn) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            modelCount = 0;
        end else if (wbv) begin
            model[d] = wbd;
            modelCount = (modelCount + 1) % (1 << CNTW);
        end
        #1;
    endtask

    initial begin
        bit       rw, mtr, rstn;
        logic [4:0] d, a, b;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        modelCount = 0;

        // Reset for two cycles. Register state is undefined before the first reset edge.
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31, 1'b0, 1'b1);
        // Reset then read: all zero, and the counter is cleared.
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd31, 1'b1, 1'b1);
        check("reset_rs5", rsData, 32'd0);
        check("reset_cnt", {28'd0, WrCount}, 32'd0);

        // ALU writeback to r8, then read it back.
        step(1'b1, 1'b0, 32'hAAAA_0000, 32'h1234_5678, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd8, 5'd0, 1'b1, 1'b1);
        check("alu_wb_r8", rsData, 32'h1234_5678);
        check("alu_wb_cnt", {28'd0, WrCount}, 32'd1);

        // Load writeback to r9 while both ports read r9.
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd9, 1'b1, 1'b1);
        check("load_next_rt9", rtData, 32'hDEAD_BEEF);

        // $zero protection: the write is dropped, WBValid stays low, and the count holds.
        step(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        check("zero_wbvalid", {31'd0, WBValid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1);
        check("zero_rs0", rsData, 32'd0);
        check("zero_cnt", {28'd0, WrCount}, 32'd2);

        // Reset priority over a simultaneous write to r3.
        step(1'b1, 1'b0, 32'd0, 32'd7, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd9, 1'b1, 1'b1);
        check("rstprio_r3", rsData, 32'd0);
        check("rstprio_cnt", {28'd0, WrCount}, 32'd0);

        // Counter wrap: 16 valid writes to r1 bring WrCount to 15, then to 0.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 32'd0, 32'h100 + i, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
            if (i == 15) check("wrap_cnt15", {28'd0, WrCount}, 32'd15);
        end
        step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1);
        check("wrap_cnt0", {28'd0, WrCount}, 32'd0);
        check("wrap_r1", rsData, 32'h110);

        // Randomized traffic with occasional mid-stream resets. Reads often
        // target the register being written, to exercise the bypass path.
        for (int n = 0; n < 300; n++) begin
            rw   = ($urandom_range(0, 3) != 0);
            mtr  = $urandom_range(0, 1);
            d    = 5'($urandom_range(0, 31));
            a    = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            b    = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
            rstn = ($urandom_range(0, 39) != 0);
            step(rw, mtr, $urandom, $urandom, d, a, b, rstn, 1'b1);
        end

        // Final sweep of every register through both ports.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i), 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
